vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 92 +++++++++
 tb/tb_vga_timing_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, coordinate decode, sync pulses and colour gating.
// Sync and blanking are delayed one cycle to line up with the scene's registered colour.
module vga_timing_gen #(
    parameter int h_video = 640,
    parameter int h_front = 16,
    parameter int h_sync  = 96,
    parameter int h_back  = 48,
    parameter int v_video = 480,
    parameter int v_front = 10,
    parameter int v_sync  = 2,
    parameter int v_back  = 33
) (
    input  logic       clk_0,
    input  logic       rst,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       frame_start,
    output logic [7:0] frame_count,
    input  logic       scene_red,
    input  logic       scene_green,
    input  logic       scene_blue,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic       hsync_n,
    output logic       vsync_n
);

    localparam logic [9:0] h_active_end = 10'(h_video);
    localparam logic [9:0] h_sync_start = 10'(h_video + h_front);
    localparam logic [9:0] h_sync_end   = 10'(h_video + h_front + h_sync);
    localparam logic [9:0] h_last       = 10'(h_video + h_front + h_sync + h_back - 1);
    localparam logic [9:0] v_active_end = 10'(v_video);
    localparam logic [9:0] v_sync_start = 10'(v_video + v_front);
    localparam logic [9:0] v_sync_end   = 10'(v_video + v_front + v_sync);
    localparam logic [9:0] v_last       = 10'(v_video + v_front + v_sync + v_back - 1);

    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       h_end;
    logic       v_end;
    logic       hsync_active;
    logic       vsync_active;
    logic       video_on_d;

    assign h_end = (h_count == h_last);
    assign v_end = (v_count == v_last);

    assign hsync_active = (h_count >= h_sync_start) && (h_count < h_sync_end);
    assign vsync_active = (v_count >= v_sync_start) && (v_count < v_sync_end);

    assign pixel_x     = h_count;
    assign pixel_y     = v_count;
    // rst is folded in so the scene sees no active pixels while held in reset.
    assign video_on    = (h_count < h_active_end) && (v_count < v_active_end) && rst;
    assign frame_start = (h_count == 10'd0) && (v_count == 10'd0) && rst;

    always_ff @(posedge clk_0) begin
        if (!rst) begin
            h_count     <= 10'd0;
            v_count     <= 10'd0;
            frame_count <= 8'd0;
        end else begin
            h_count <= h_end ? 10'd0 : h_count + 10'd1;
            if (h_end) begin
                v_count <= v_end ? 10'd0 : v_count + 10'd1;
            end
            if (h_end && v_end) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    // Alignment stage: matches the one-cycle latency of the scene's colour register.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            hsync_n    <= 1'b1;
            vsync_n    <= 1'b1;
            video_on_d <= 1'b0;
        end else begin
            hsync_n    <= ~hsync_active;
            vsync_n    <= ~vsync_active;
            video_on_d <= video_on;
        end
    end

    assign red   = scene_red   & video_on_d;
    assign green = scene_green & video_on_d;
    assign blue  = scene_blue  & video_on_d;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance for reset/line timing, and a
// shrunken 15x10 instance for frame timing, mid-frame reset and frame_count wrap.
module tb_vga_timing_gen;

    logic clk_0 = 1'b0;
    always #5 clk_0 = ~clk_0;

    // Default-parameter instance
    logic       rst_a;
    logic [9:0] px_a, py_a;
    logic       von_a, fs_a, r_a, g_a, b_a, hs_a, vs_a;
    logic [7:0] fc_a;
    logic       sr_a, sg_a, sb_a;

    // Small instance: h 8/2/3/2 (total 15), v 6/1/2/1 (total 10), frame 150 cycles
    logic       rst_b;
    logic [9:0] px_b, py_b;
    logic       von_b, fs_b, r_b, g_b, b_b, hs_b, vs_b;
    logic [7:0] fc_b;
    logic       sr_b, sg_b, sb_b;

    vga_timing_gen dut_a (
        .clk_0(clk_0), .rst(rst_a), .pixel_x(px_a), .pixel_y(py_a), .video_on(von_a),
        .frame_start(fs_a), .frame_count(fc_a), .scene_red(sr_a), .scene_green(sg_a),
        .scene_blue(sb_a), .red(r_a), .green(g_a), .blue(b_a), .hsync_n(hs_a), .vsync_n(vs_a)
    );

    vga_timing_gen #(
        .h_video(8), .h_front(2), .h_sync(3), .h_back(2),
        .v_video(6), .v_front(1), .v_sync(2), .v_back(1)
    ) dut_b (
        .clk_0(clk_0), .rst(rst_b), .pixel_x(px_b), .pixel_y(py_b), .video_on(von_b),
        .frame_start(fs_b), .frame_count(fc_b), .scene_red(sr_b), .scene_green(sg_b),
        .scene_blue(sb_b), .red(r_b), .green(g_b), .blue(b_b), .hsync_n(hs_b), .vsync_n(vs_b)
    );

    typedef struct {
        int k;
        int x;
        int y;
        bit von;
        bit fs;
        bit hs;
        bit vs;
        bit col;
    } vec_t;

    vec_t vecs[12];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_0);
        #1;
    endtask

    initial begin
        int vi, hs_low, col_cnt, vs_low, first_vs, fs_cnt;

        // k = cycles since reset release; scene colour constant 3'b101 on dut_a
        vecs[0]  = '{k:0,   x:0,   y:0, von:1, fs:1, hs:1, vs:1, col:0};
        vecs[1]  = '{k:1,   x:1,   y:0, von:1, fs:0, hs:1, vs:1, col:1};
        vecs[2]  = '{k:639, x:639, y:0, von:1, fs:0, hs:1, vs:1, col:1};
        vecs[3]  = '{k:640, x:640, y:0, von:0, fs:0, hs:1, vs:1, col:1};
        vecs[4]  = '{k:641, x:641, y:0, von:0, fs:0, hs:1, vs:1, col:0};
        vecs[5]  = '{k:656, x:656, y:0, von:0, fs:0, hs:1, vs:1, col:0};
        vecs[6]  = '{k:657, x:657, y:0, von:0, fs:0, hs:0, vs:1, col:0};
        vecs[7]  = '{k:752, x:752, y:0, von:0, fs:0, hs:0, vs:1, col:0};
        vecs[8]  = '{k:753, x:753, y:0, von:0, fs:0, hs:1, vs:1, col:0};
        vecs[9]  = '{k:799, x:799, y:0, von:0, fs:0, hs:1, vs:1, col:0};
        vecs[10] = '{k:800, x:0,   y:1, von:1, fs:0, hs:1, vs:1, col:0};
        vecs[11] = '{k:801, x:1,   y:1, von:1, fs:0, hs:1, vs:1, col:1};

        rst_a = 1'b0; rst_b = 1'b0;
        sr_a = 1'b1; sg_a = 1'b0; sb_a = 1'b1;
        sr_b = 1'b1; sg_b = 1'b1; sb_b = 1'b1;

        // Reset hold
        repeat (5) step();
        chk("rst_video_on", von_a, 0);
        chk("rst_frame_start", fs_a, 0);
        chk("rst_rgb", {r_a, g_a, b_a}, 0);
        chk("rst_hsync_n", hs_a, 1);
        chk("rst_vsync_n", vs_a, 1);
        chk("rst_pixel_x", px_a, 0);

        // Line timing on the default instance
        rst_a = 1'b1;
        #1;
        vi = 0; hs_low = 0; col_cnt = 0;
        for (int k = 0; k <= 801; k++) begin
            if (k > 0) step();
            if (k >= 1 && k <= 800) begin
                if (!hs_a) hs_low++;
                if (r_a) col_cnt++;
            end
            if (vi < 12 && vecs[vi].k == k) begin
                chk($sformatf("v%0d_pixel_x", k), px_a, vecs[vi].x);
                chk($sformatf("v%0d_pixel_y", k), py_a, vecs[vi].y);
                chk($sformatf("v%0d_video_on", k), von_a, vecs[vi].von);
                chk($sformatf("v%0d_frame_start", k), fs_a, vecs[vi].fs);
                chk($sformatf("v%0d_hsync_n", k), hs_a, vecs[vi].hs);
                chk($sformatf("v%0d_vsync_n", k), vs_a, vecs[vi].vs);
                chk($sformatf("v%0d_rgb", k), {r_a, g_a, b_a}, vecs[vi].col ? 3'b101 : 3'b000);
                vi++;
            end
        end
        chk("line_hsync_low_cycles", hs_low, 96);
        chk("line_colour_cycles", col_cnt, 640);

        // Frame timing on the small instance
        step();
        rst_b = 1'b1;
        #1;
        chk("b_rel_pixel_x", px_b, 0);
        chk("b_rel_pixel_y", py_b, 0);
        chk("b_rel_frame_start", fs_b, 1);
        chk("b_rel_frame_count", fc_b, 0);
        chk("b_rel_hsync_n", hs_b, 1);
        chk("b_rel_vsync_n", vs_b, 1);
        chk("b_rel_rgb", {r_b, g_b, b_b}, 0);
        vs_low = 0; first_vs = -1; fs_cnt = 0; hs_low = 0; col_cnt = 0;
        for (int k = 1; k <= 150; k++) begin
            step();
            if (!vs_b) begin
                vs_low++;
                if (first_vs < 0) first_vs = k;
            end
            if (fs_b) fs_cnt++;
            if (!hs_b) hs_low++;
            if (r_b) col_cnt++;
            if (k == 1) chk("b_k1_frame_start", fs_b, 0);
            if (k == 149) begin
                chk("b_k149_pixel_x", px_b, 14);
                chk("b_k149_pixel_y", py_b, 9);
                chk("b_k149_frame_count", fc_b, 0);
            end
        end
        chk("b_wrap_pixel_x", px_b, 0);
        chk("b_wrap_pixel_y", py_b, 0);
        chk("b_wrap_frame_count", fc_b, 1);
        chk("b_wrap_frame_start", fs_b, 1);
        chk("b_frame_start_pulses", fs_cnt, 1);
        chk("b_vsync_low_cycles", vs_low, 30);
        chk("b_vsync_first_low", first_vs, 106);
        chk("b_hsync_low_cycles", hs_low, 30);
        chk("b_colour_cycles", col_cnt, 48);

        // Mid-frame reset at (11,7): inside both sync regions
        for (int k = 151; k <= 266; k++) step();
        chk("b_pre_rst_pixel_x", px_b, 11);
        chk("b_pre_rst_pixel_y", py_b, 7);
        chk("b_pre_rst_hsync_n", hs_b, 0);
        chk("b_pre_rst_vsync_n", vs_b, 0);
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        #1;
        chk("b_mid_rst_pixel_x", px_b, 0);
        chk("b_mid_rst_pixel_y", py_b, 0);
        chk("b_mid_rst_hsync_n", hs_b, 1);
        chk("b_mid_rst_vsync_n", vs_b, 1);
        chk("b_mid_rst_rgb", {r_b, g_b, b_b}, 0);
        chk("b_mid_rst_frame_count", fc_b, 0);
        chk("b_mid_rst_frame_start", fs_b, 1);

        // 256 frames: frame_count steps each frame and wraps 255 -> 0
        hs_low = 0; vs_low = 0; fs_cnt = 0;
        for (int k = 1; k <= 256 * 150; k++) begin
            step();
            if (!hs_b) hs_low++;
            if (!vs_b) vs_low++;
            if (fs_b) fs_cnt++;
            if (k % 150 == 0) begin
                chk($sformatf("b_fc_frame%0d", k / 150), fc_b, (k / 150) % 256);
                chk($sformatf("b_fs_frame%0d", k / 150), fs_b, 1);
                chk($sformatf("b_hs_frame%0d", k / 150), hs_b, 1);
                chk($sformatf("b_vs_frame%0d", k / 150), vs_b, 1);
            end else if (k % 150 == 75) begin
                chk($sformatf("b_fc_mid%0d", k / 150), fc_b, k / 150);
            end
            if (k == 256 * 150 - 1) chk("b_fc_before_wrap", fc_b, 255);
        end
        chk("b_fc_after_wrap", fc_b, 0);
        chk("b_256_hsync_low", hs_low, 256 * 30);
        chk("b_256_vsync_low", vs_low, 256 * 30);
        chk("b_256_frame_starts", fs_cnt, 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
